// File: rtl/texto_rom_ctrl_pkg.sv
// Shared constants for the text overlay: glyph codes, glyph cell geometry
// and the RGB332 colours used by the overlay.
package texto_rom_ctrl_pkg;

    localparam logic [2:0] GLYPH_SPACE = 3'd0;
    localparam logic [2:0] GLYPH_J     = 3'd1;
    localparam logic [2:0] GLYPH_V     = 3'd2;
    localparam logic [2:0] GLYPH_M     = 3'd3;
    localparam logic [2:0] GLYPH_B     = 3'd4;
    localparam logic [2:0] GLYPH_S     = 3'd5;
    localparam logic [2:0] GLYPH_L     = 3'd6;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_GREEN = 8'h1C;
    localparam logic [7:0] RGB_BLUE  = 8'h03;

endpackage

// File: rtl/texto_rom_ctrl_slot_regs.sv
// NCHAR x 3-bit glyph string with one write port and an asynchronous read.
// Reads in the same clock as a write see the previous code.
module texto_slot_regs
    import texto_rom_ctrl_pkg::*;
#(
    parameter int NCHAR = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_code,
    input  logic [2:0] rd_addr,
    output logic [2:0] rd_code
);

    logic [2:0] slot_q [NCHAR];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCHAR; i++) begin
                slot_q[i] <= GLYPH_SPACE;
            end
        end else if (wr_en && (int'(wr_addr) < NCHAR)) begin
            slot_q[wr_addr] <= wr_code;
        end
    end

    assign rd_code = (int'(rd_addr) < NCHAR) ? slot_q[rd_addr] : GLYPH_SPACE;

endmodule

// File: rtl/texto_rom_ctrl.sv
// Text overlay: maps pixel coordinates onto a glyph string, drives the
// external glyph ROM and returns a 2-tick pipelined colour plus delayed syncs.
module texto_rom_ctrl
    import texto_rom_ctrl_pkg::*;
#(
    parameter int         X0    = 256,
    parameter int         Y0    = 224,
    parameter int         NCHAR = 8,
    parameter logic [7:0] FG    = RGB_WHITE,
    parameter logic [7:0] BG    = RGB_BLACK
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       text_en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [2:0] wr_code,
    output logic [2:0] direccion,
    output logic [3:0] rom,
    input  logic [7:0] rom_data,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out
);

    // 11-bit bounds so the exclusive right/bottom edges cannot wrap
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + GLYPH_W * NCHAR);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + GLYPH_H);

    logic [5:0] dx;
    logic [3:0] dy;
    logic       in_win;
    logic [2:0] slot_code;

    logic [2:0] bit_a;
    logic       win_a;
    logic       vid_a;
    logic       hs_a;
    logic       vs_a;
    logic       pix_on;

    assign dx = 6'(pixel_x - 10'(X0));
    assign dy = 4'(pixel_y - 10'(Y0));

    assign in_win = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                    ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

    texto_slot_regs #(
        .NCHAR (NCHAR)
    ) u_slot_regs (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_code (wr_code),
        .rd_addr (dx[5:3]),
        .rd_code (slot_code)
    );

    // Stage A: ROM address plus the side-band that must travel with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            direccion <= '0;
            rom       <= '0;
            bit_a     <= '0;
            win_a     <= 1'b0;
            vid_a     <= 1'b0;
            hs_a      <= 1'b1;
            vs_a      <= 1'b1;
        end else if (pix_tick) begin
            direccion <= in_win ? slot_code : GLYPH_SPACE;
            rom       <= dy;
            bit_a     <= dx[2:0];
            win_a     <= in_win & text_en;
            vid_a     <= video_on;
            hs_a      <= hsync_in;
            vs_a      <= vsync_in;
        end
    end

    assign pix_on = win_a & rom_data[3'd7 - bit_a];

    // Stage B: colour select against the ROM row returned for stage A
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (pix_tick) begin
            rgb       <= !vid_a ? 8'h00 : (pix_on ? FG : BG);
            hsync_out <= hs_a;
            vsync_out <= vs_a;
        end
    end

endmodule

// File: tb/tb_texto_rom_ctrl.sv
// Directed bench for texto_rom_ctrl: two instances (NCHAR 8 default colours,
// NCHAR 6 with distinct FG/BG) sharing stimulus, each with a small glyph ROM.
module tb_texto_rom_ctrl;
    import texto_rom_ctrl_pkg::*;

    localparam int X0 = 256;
    localparam int Y0 = 224;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       text_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_code;

    logic [2:0] direccion, direccion6;
    logic [3:0] rom, rom6;
    logic [7:0] rom_data, rom_data6;
    logic [7:0] rgb, rgb6;
    logic       hsync_out, hsync_out6;
    logic       vsync_out, vsync_out6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bench glyph ROM: rows 0 and 15 blank, codes 0 and 7 all blank
    function automatic logic [7:0] rom_fn(input logic [2:0] g, input logic [3:0] r);
        if (r == 4'd0 || r == 4'd15) return 8'h00;
        case (g)
            3'd1:    return 8'h7E;
            3'd2:    return 8'h81;
            3'd3:    return 8'hC3;
            3'd4:    return 8'hFC;
            3'd5:    return 8'h3C;
            3'd6:    return 8'hC0;
            default: return 8'h00;
        endcase
    endfunction

    assign rom_data  = rom_fn(direccion, rom);
    assign rom_data6 = rom_fn(direccion6, rom6);

    texto_rom_ctrl #(.X0(X0), .Y0(Y0), .NCHAR(8)) dut (
        .clk(clk), .reset_n(reset_n), .pix_tick(pix_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .text_en(text_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .direccion(direccion), .rom(rom), .rom_data(rom_data),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    texto_rom_ctrl #(.X0(X0), .Y0(Y0), .NCHAR(6), .FG(8'hE0), .BG(8'h25)) dut6 (
        .clk(clk), .reset_n(reset_n), .pix_tick(pix_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .text_en(text_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .direccion(direccion6), .rom(rom6), .rom_data(rom_data6),
        .rgb(rgb6), .hsync_out(hsync_out6), .vsync_out(vsync_out6)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk cycle of stimulus, then outputs are sampled at the following negedge
    task automatic step(input logic pt, input logic [9:0] x, input logic [9:0] y,
                        input logic we, input logic [2:0] wa, input logic [2:0] wc);
        @(negedge clk);
        pix_tick = pt;
        pixel_x  = x;
        pixel_y  = y;
        wr_en    = we;
        wr_addr  = wa;
        wr_code  = wc;
        @(negedge clk);
        pix_tick = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic tick(input int x, input int y);
        step(1'b1, 10'(x), 10'(y), 1'b0, 3'd0, 3'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] c);
        step(1'b0, 10'd0, 10'd0, 1'b1, a, c);
    endtask

    logic [7:0] exp_j [8];

    initial begin
        exp_j = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        reset_n  = 1'b0;
        pix_tick = 1'b0;
        pixel_x  = '0;
        pixel_y  = '0;
        video_on = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        text_en  = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_code  = '0;

        // Reset held while ticks run mid-line
        for (int i = 0; i < 3; i++) tick(X0 + i, Y0 + 2);
        check("rst_rgb", rgb, 8'h00);
        check("rst_hsync", {7'b0, hsync_out}, 8'h01);
        check("rst_vsync", {7'b0, vsync_out}, 8'h01);
        check("rst_direccion", {5'b0, direccion}, 8'h00);
        check("rst_rom", {4'b0, rom}, 8'h00);

        @(negedge clk);
        reset_n  = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;

        // Empty string renders BG inside the window
        tick(X0 + 1, Y0 + 2);
        check("empty_direccion", {5'b0, direccion}, 8'h00);
        tick(X0 + 2, Y0 + 2);
        check("empty_rgb6_bg", rgb6, 8'h25);

        // Single glyph J in slot 0, row 2 = 0x7E
        wr(3'd0, GLYPH_J);
        for (int i = 0; i < 9; i++) begin
            tick(X0 + i, Y0 + 2);
            if (i < 8) begin
                check($sformatf("j_dir_%0d", i), {5'b0, direccion}, 8'h01);
                check($sformatf("j_rom_%0d", i), {4'b0, rom}, 8'h02);
            end
            if (i > 0) check($sformatf("j_rgb_%0d", i - 1), rgb, exp_j[i - 1]);
        end

        // Window edges; slot 7 = B, slot 5 = L
        wr(3'd7, GLYPH_B);
        wr(3'd5, GLYPH_L);
        tick(X0 - 1, Y0 + 2);
        check("edge_left_out_dir", {5'b0, direccion}, 8'h00);
        tick(X0 + 56, Y0 + 2);
        check("edge_slot7_dir", {5'b0, direccion}, 8'h04);
        tick(X0 + 56, Y0 + 2);
        check("edge_slot7_rgb", rgb, 8'hFF);
        tick(X0 + 64, Y0 + 2);
        check("edge_right_out_dir", {5'b0, direccion}, 8'h00);
        tick(X0 + 64, Y0 + 2);
        check("edge_right_out_rgb", rgb, 8'h00);
        tick(X0 + 1, Y0 + 15);
        check("edge_y15_dir", {5'b0, direccion}, 8'h01);
        check("edge_y15_rom", {4'b0, rom}, 8'h0F);
        tick(X0 + 1, Y0 + 15);
        check("edge_y15_rgb", rgb, 8'h00);
        tick(X0 + 1, Y0 + 16);
        check("edge_y16_dir", {5'b0, direccion}, 8'h00);
        tick(X0 + 1, Y0 - 1);
        check("edge_ym1_dir", {5'b0, direccion}, 8'h00);
        check("edge_ym1_rom", {4'b0, rom}, 8'h0F);
        tick(X0 + 1, Y0);
        check("edge_y0_dir", {5'b0, direccion}, 8'h01);
        tick(X0 + 40, Y0 + 2);
        check("n6_slot5_dir", {5'b0, direccion6}, 8'h06);
        tick(X0 + 40, Y0 + 2);
        check("n6_slot5_rgb", rgb6, 8'hE0);
        tick(X0 + 48, Y0 + 2);
        check("n6_right_out_dir", {5'b0, direccion6}, 8'h00);
        tick(X0 + 48, Y0 + 2);
        check("n6_right_out_rgb", rgb6, 8'h25);

        // Write collision on slot 3 (B -> V); pixel bit 1: B=1, V=0
        wr(3'd3, GLYPH_B);
        step(1'b1, 10'(X0 + 25), 10'(Y0 + 5), 1'b1, 3'd3, GLYPH_V);
        check("coll_old_dir", {5'b0, direccion}, 8'h04);
        tick(X0 + 25, Y0 + 5);
        check("coll_new_dir", {5'b0, direccion}, 8'h02);
        check("coll_old_rgb", rgb, 8'hFF);
        tick(X0 + 25, Y0 + 5);
        check("coll_new_rgb", rgb, 8'h00);

        // Sync delay and hold during pix_tick gaps
        hsync_in = 1'b0;
        tick(X0 + 1, Y0 + 2);
        check("hs_n_plus1", {7'b0, hsync_out}, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b0, 10'(X0 + 56), 10'(Y0 + 2), 1'b0, 3'd0, 3'd0);
        check("gap_hsync", {7'b0, hsync_out}, 8'h01);
        check("gap_dir", {5'b0, direccion}, 8'h01);
        check("gap_rgb", rgb, 8'h00);
        tick(X0 + 1, Y0 + 2);
        check("hs_n_plus2", {7'b0, hsync_out}, 8'h00);
        check("gap_rgb_after", rgb, 8'hFF);
        vsync_in = 1'b0;
        tick(X0 + 1, Y0 + 2);
        check("vs_n_plus1", {7'b0, vsync_out}, 8'h01);
        tick(X0 + 1, Y0 + 2);
        check("vs_n_plus2", {7'b0, vsync_out}, 8'h00);

        // Blanking via text_en and video_on
        text_en = 1'b0;
        tick(X0 + 1, Y0 + 2);
        check("txt_off_lag", rgb6, 8'hE0);
        tick(X0 + 1, Y0 + 2);
        check("txt_off_rgb6", rgb6, 8'h25);
        check("txt_off_rgb", rgb, 8'h00);
        text_en  = 1'b1;
        video_on = 1'b0;
        tick(X0 + 1, Y0 + 2);
        tick(X0 + 1, Y0 + 2);
        check("vid_off_rgb6", rgb6, 8'h00);
        video_on = 1'b1;
        tick(X0 + 1, Y0 + 2);
        tick(X0 + 1, Y0 + 2);
        check("vid_on_rgb6", rgb6, 8'hE0);

        // Asynchronous reset mid-frame clears outputs and the string
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rgb", rgb, 8'h00);
        check("midrst_hsync", {7'b0, hsync_out}, 8'h01);
        check("midrst_dir", {5'b0, direccion}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick(X0 + 1, Y0 + 2);
        check("postrst_dir", {5'b0, direccion}, 8'h00);
        tick(X0 + 1, Y0 + 2);
        check("postrst_rgb6", rgb6, 8'h25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
